// File: rtl/gf163_pkg.sv
// -----------------------------------------------------------------------------
// gf163_pkg
// Shared definitions for the GF(2^163) Itoh-Tsujii inverter:
//   M_DEG     field degree (163)
//   RED_POLY  low byte of f = x^163 + x^7 + x^6 + x^3 + 1 (x^163 folds onto it)
//   CHAIN     binary expansion of 162 = m-1, walked MSB-first by the inverter
//   state_t   inverter FSM encoding
//   step_t    kind of addition-chain step in progress
// -----------------------------------------------------------------------------
package gf163_pkg;

  localparam int         M_DEG     = 163;
  localparam logic [7:0] RED_POLY  = 8'hC9;
  localparam logic [7:0] CHAIN     = 8'b10100010;
  // Index of the first chain bit after the leading one.
  localparam int         CHAIN_TOP = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQR,
    ST_MUL_REQ,
    ST_MUL_WAIT,
    ST_FINAL,
    ST_DONE
  } state_t;

  // Doubling step: b = b^(2^k) * b, k = 2k.  Increment step: b = b^2 * a, k = k+1.
  typedef enum logic {
    STEP_DBL,
    STEP_INC
  } step_t;

endpackage

// File: rtl/gf163_sqr.sv
// -----------------------------------------------------------------------------
// gf163_sqr
// Combinational squaring in GF(2^163) with f = x^163 + x^7 + x^6 + x^3 + 1.
// Squaring spreads bit i to bit 2i (325-bit result), then every term at or
// above x^163 is folded down using x^163 = x^7 + x^6 + x^3 + 1.
// Ports:
//   a  operand (163 bits)
//   z  a^2 mod f (163 bits)
// -----------------------------------------------------------------------------
module gf163_sqr
  import gf163_pkg::*;
(
  input  logic [M_DEG-1:0] a,
  output logic [M_DEG-1:0] z
);

  always_comb begin
    logic [2*M_DEG-2:0] t;
    // NOTE: combinational logic uses blocking '=' so each reduction pass sees
    // the result of the previous one; clocked state elsewhere uses '<='.
    t = '0;
    for (int i = 0; i < M_DEG; i++) begin
      t[2*i] = a[i];
    end
    // Fold from the top down: a folded term can land at up to x^(i-156),
    // which is still above x^163 for the highest i and gets folded later.
    for (int i = 2*M_DEG-2; i >= M_DEG; i--) begin
      if (t[i]) begin
        t[i] = 1'b0;
        for (int j = 0; j < 8; j++) begin
          if (RED_POLY[j]) begin
            t[i-M_DEG+j] = ~t[i-M_DEG+j];
          end
        end
      end
    end
    z = t[M_DEG-1:0];
  end

endmodule

// File: rtl/gf163_inv_itoh.sv
// -----------------------------------------------------------------------------
// gf163_inv_itoh
// Itoh-Tsujii inversion in GF(2^163): z = (a^(2^162-1))^2 = a^-1 mod f.
// One squaring per cycle through a single gf163_sqr; the 9 field
// multiplications of the addition chain for 162 are handed to an external
// multiplier over a level-start / pulse-done handshake.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        launch an inversion of a_in (sampled in IDLE only)
//   a_in         operand, captured on the accepted start
//   z            result, held until the next accepted start
//   done         one-cycle pulse, z valid from this cycle
//   busy         high from the accepted start until done
//   mul_start    level request to the multiplier, held until mul_done
//   mul_a/mul_b  multiplier operands, stable while mul_start is high
//   mul_z        multiplier product, valid the cycle after mul_done
//   mul_done     multiplier completion pulse (ignored outside MUL_WAIT)
//   inv_zero     (GF_INV_ZERO_FLAG_EN only) operand was zero, valid with done
//
// Build option: define GF_INV_ZERO_FLAG_EN to add inv_zero and to finish a
// zero operand immediately without running the chain.
// Only M = 163 is supported.
// -----------------------------------------------------------------------------
module gf163_inv_itoh
  import gf163_pkg::*;
#(
  parameter int M = 163
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] a_in,
  output logic [M-1:0] z,
  output logic         done,
  output logic         busy,
  output logic         mul_start,
  output logic [M-1:0] mul_a,
  output logic [M-1:0] mul_b,
  input  logic [M-1:0] mul_z,
`ifdef GF_INV_ZERO_FLAG_EN
  output logic         inv_zero,
`endif
  input  logic         mul_done
);

  state_t       state;
  step_t        step;
  logic [M-1:0] a_reg;     // captured operand, B input of increment steps
  logic [M-1:0] b;         // running accumulator being squared
  logic [M-1:0] b_saved;   // accumulator value at the start of a doubling step
  logic [7:0]   k;         // current exponent: b = a^(2^k - 1) at step boundaries
  logic [7:0]   cnt;       // squarings left in the current step
  logic [2:0]   bit_idx;   // chain bit currently being processed
  logic         prod_pend; // product arrived last cycle; take it from mul_z

  logic [M-1:0] sqr_in;
  logic [M-1:0] sqr_out;
  logic [7:0]   k_next;

  // The product is registered by the multiplier in its done cycle, so the
  // first cycle after MUL_WAIT squares mul_z directly instead of b.
  assign sqr_in = prod_pend ? mul_z : b;

  always_comb begin
    k_next = (step == STEP_DBL) ? {k[6:0], 1'b0} : k + 8'd1;
  end

  gf163_sqr u_sqr (
    .a (sqr_in),
    .z (sqr_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, data paths included, is cleared because the
      // outputs z/mul_a/mul_b must read zero after reset, not stale values.
      state     <= ST_IDLE;
      step      <= STEP_DBL;
      a_reg     <= '0;
      b         <= '0;
      b_saved   <= '0;
      k         <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
      prod_pend <= 1'b0;
      z         <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
`ifdef GF_INV_ZERO_FLAG_EN
      inv_zero  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_reg     <= a_in;
            b         <= a_in;
            b_saved   <= a_in;
            k         <= 8'd1;
            cnt       <= 8'd1;
            bit_idx   <= 3'(CHAIN_TOP);
            step      <= STEP_DBL;
            prod_pend <= 1'b0;
            busy      <= 1'b1;
`ifdef GF_INV_ZERO_FLAG_EN
            inv_zero  <= (a_in == '0);
            if (a_in == '0) begin
              z     <= '0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_SQR;
            end
`else
            state     <= ST_SQR;
`endif
          end
        end

        ST_SQR: begin
          b         <= sqr_out;
          prod_pend <= 1'b0;
          if (prod_pend) begin
            b_saved <= mul_z;
          end
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            mul_a <= sqr_out;
            if (step == STEP_DBL) begin
              mul_b <= prod_pend ? mul_z : b_saved;
            end else begin
              mul_b <= a_reg;
            end
            mul_start <= 1'b1;
            state     <= ST_MUL_REQ;
          end
        end

        ST_MUL_REQ: begin
          state <= ST_MUL_WAIT;
        end

        ST_MUL_WAIT: begin
          if (mul_done) begin
            mul_start <= 1'b0;
            prod_pend <= 1'b1;
            k         <= k_next;
            if (step == STEP_DBL && CHAIN[bit_idx]) begin
              // Chain bit is one: follow the doubling with b = b^2 * a.
              step  <= STEP_INC;
              cnt   <= 8'd1;
              state <= ST_SQR;
            end else if (bit_idx == '0) begin
              state <= ST_FINAL;
            end else begin
              bit_idx <= bit_idx - 3'd1;
              step    <= STEP_DBL;
              cnt     <= k_next;
              state   <= ST_SQR;
            end
          end
        end

        ST_FINAL: begin
          z         <= sqr_out;
          prod_pend <= 1'b0;
          done      <= 1'b1;
          state     <= ST_DONE;
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf163_inv_itoh.sv
// -----------------------------------------------------------------------------
// tb_gf163_inv_itoh
// Self-checking bench for gf163_inv_itoh. A behavioural multiplier with
// randomised latency answers the DUT's requests; results are checked against
// a reference inverse computed as the product of a^(2^i), i = 1..162, and
// against the defining property z * a = 1.
// Build option: GF_INV_ZERO_FLAG_EN (must match the RTL build).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gf163_inv_itoh;

  localparam int M = 163;
  localparam int BUDGET = 6000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [M-1:0] a_in = '0;
  logic [M-1:0] z;
  logic         done;
  logic         busy;
  logic         mul_start;
  logic [M-1:0] mul_a;
  logic [M-1:0] mul_b;
  logic [M-1:0] mul_z;
  logic         mul_done;
`ifdef GF_INV_ZERO_FLAG_EN
  logic         inv_zero;
`endif

  int total = 0;
  int bad   = 0;

  int   n_mul  = 0;
  int   n_done = 0;
  logic ms_prev = 1'b0;

  int min_lat = 1;
  int max_lat = 1;
  int mcnt;
  int mlat;
  logic [M-1:0] mprod;

  always #5 clk = ~clk;

  gf163_inv_itoh #(.M(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_in      (a_in),
    .z         (z),
    .done      (done),
    .busy      (busy),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_z     (mul_z),
`ifdef GF_INV_ZERO_FLAG_EN
    .inv_zero  (inv_zero),
`endif
    .mul_done  (mul_done)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] r;
    logic [M-1:0] s;
    logic         c;
    r = '0;
    s = x;
    for (int i = 0; i < M; i++) begin
      if (y[i]) r = r ^ s;
      c = s[M-1];
      s = s << 1;
      if (c) s = s ^ {{(M-8){1'b0}}, 8'hC9};
    end
    return r;
  endfunction

  // a^-1 = a^(2^163 - 2) = prod_{i=1..162} a^(2^i)
  function automatic logic [M-1:0] gf_inv(input logic [M-1:0] x);
    logic [M-1:0] r;
    logic [M-1:0] s;
    r = {{(M-1){1'b0}}, 1'b1};
    s = x;
    for (int i = 1; i < M; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [M-1:0] rand_elem();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (w[M-1:0] == '0) w[0] = 1'b1;
    return w[M-1:0];
  endfunction

  // ---------------- behavioural multiplier ----------------
  // Counts cycles with start high, pulses done after the chosen latency and
  // publishes the product one cycle later.
  always @(posedge clk or negedge rst_n) begin : mul_model
    int lat_now;
    if (!rst_n) begin
      mul_done <= 1'b0;
      mul_z    <= '0;
      mprod    <= '0;
      mcnt     <= 0;
      mlat     <= 1;
    end else begin
      mul_done <= 1'b0;
      if (mul_done) begin
        mul_z <= mprod;
      end else if (mul_start) begin
        lat_now = (mcnt == 0) ? int'($urandom_range(max_lat, min_lat)) : mlat;
        mlat <= lat_now;
        if (mcnt + 1 >= lat_now) begin
          mul_done <= 1'b1;
          mprod    <= gf_mul(mul_a, mul_b);
          mcnt     <= 0;
        end else begin
          mcnt <= mcnt + 1;
        end
      end else begin
        mcnt <= 0;
      end
    end
  end

  // Event counters sampled away from the active edge.
  always @(negedge clk) begin
    if (mul_start && !ms_prev) n_mul++;
    ms_prev = mul_start;
    if (done) n_done++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(output logic ok, output int cyc);
    cyc = 1;
    ok  = done;
    while (!ok && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      ok = done;
    end
  endtask

  task automatic run_inv(input logic [M-1:0] a, input string tag,
                         output logic [M-1:0] zr, output int cyc);
    logic ok;
    @(negedge clk);
    a_in   = a;
    start  = 1'b1;
    n_mul  = 0;
    n_done = 0;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok, cyc);
    zr = z;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout: done not seen after %0d cycles, required within %0d", tag, cyc, BUDGET);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({done, busy, mul_start} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl: done/busy/mul_start=%b required 000", {done, busy, mul_start});
    end
    total++;
    if (z !== '0) begin
      bad++;
      $display("FAIL reset_z: got %h required 0", z);
    end
    total++;
    if ({mul_a, mul_b} !== '0) begin
      bad++;
      $display("FAIL reset_mul_ops: mul_a=%h mul_b=%h required 0", mul_a, mul_b);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_one();
    logic [M-1:0] zr;
    int cyc;
    min_lat = 1;
    max_lat = 5;
    run_inv({{(M-1){1'b0}}, 1'b1}, "one", zr, cyc);
    total++;
    if (zr !== {{(M-1){1'b0}}, 1'b1}) begin
      bad++;
      $display("FAIL one_z: got %h required 1", zr);
    end
    repeat (3) @(negedge clk);
    total++;
    if (n_done !== 1) begin
      bad++;
      $display("FAIL one_done_count: got %0d required 1", n_done);
    end
    total++;
    if (n_mul !== 9) begin
      bad++;
      $display("FAIL one_mul_count: got %0d required 9", n_mul);
    end
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("FAIL one_idle: done/busy=%b required 00", {done, busy});
    end
  endtask

  task automatic test_x();
    logic [M-1:0] zr;
    logic [M-1:0] exp_z;
    int cyc;
    min_lat = 1;
    max_lat = 30;
    exp_z = '0;
    exp_z[162] = 1'b1;
    exp_z[6] = 1'b1;
    exp_z[5] = 1'b1;
    exp_z[2] = 1'b1;
    run_inv({{(M-2){1'b0}}, 2'b10}, "x", zr, cyc);
    total++;
    if (zr !== exp_z) begin
      bad++;
      $display("FAIL x_inverse: got %h required %h", zr, exp_z);
    end
  endtask

  task automatic test_random();
    logic [M-1:0] a;
    logic [M-1:0] zr;
    logic [M-1:0] one;
    int cyc;
    one = {{(M-1){1'b0}}, 1'b1};
    min_lat = 1;
    max_lat = 200;
    for (int n = 0; n < 20; n++) begin
      a = rand_elem();
      run_inv(a, "rand", zr, cyc);
      total++;
      if (gf_mul(zr, a) !== one) begin
        bad++;
        $display("FAIL rand_product[%0d]: a=%h z=%h z*a=%h required 1", n, a, zr, gf_mul(zr, a));
      end
      total++;
      if (zr !== gf_inv(a)) begin
        bad++;
        $display("FAIL rand_model[%0d]: got %h required %h", n, zr, gf_inv(a));
      end
      total++;
      if (n_mul !== 9) begin
        bad++;
        $display("FAIL rand_mul_count[%0d]: got %0d required 9", n, n_mul);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [M-1:0] a1;
    logic [M-1:0] a2;
    logic ok;
    int cyc;
    min_lat = 1;
    max_lat = 20;
    a1 = rand_elem();
    a2 = a1 ^ {{(M-1){1'b0}}, 1'b1} ^ {1'b0, rand_elem() >> 1};
    if (a2 == a1 || a2 == '0) a2 = a1 ^ {{(M-3){1'b0}}, 3'b100};
    @(negedge clk);
    a_in   = a1;
    start  = 1'b1;
    n_mul  = 0;
    n_done = 0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_busy: got %b required 1", busy);
    end
    a_in  = a2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok, cyc);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b2b_timeout: done not seen after %0d cycles", cyc);
    end
    total++;
    if (z !== gf_inv(a1)) begin
      bad++;
      $display("FAIL b2b_z: got %h required %h", z, gf_inv(a1));
    end
    repeat (3) @(negedge clk);
    total++;
    if (n_done !== 1 || n_mul !== 9) begin
      bad++;
      $display("FAIL b2b_counts: done=%0d mul=%0d required 1 and 9", n_done, n_mul);
    end
  endtask

  task automatic test_reset_mid();
    logic [M-1:0] zr;
    int cyc;
    int guard;
    min_lat = 50;
    max_lat = 50;
    @(negedge clk);
    a_in   = rand_elem();
    start  = 1'b1;
    n_mul  = 0;
    n_done = 0;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (n_mul < 4 && guard < BUDGET) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (n_mul < 4) begin
      bad++;
      $display("FAIL mid_reach_mul4: got %0d requests required 4", n_mul);
    end
    repeat (3) @(negedge clk);
    total++;
    if ({busy, mul_start} !== 2'b11) begin
      bad++;
      $display("FAIL mid_in_wait: busy/mul_start=%b required 11", {busy, mul_start});
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({done, busy, mul_start} !== 3'b000) begin
      bad++;
      $display("FAIL mid_reset_ctrl: done/busy/mul_start=%b required 000", {done, busy, mul_start});
    end
    total++;
    if ({z, mul_a, mul_b} !== '0) begin
      bad++;
      $display("FAIL mid_reset_data: z=%h mul_a=%h mul_b=%h required 0", z, mul_a, mul_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (n_done !== 0) begin
      bad++;
      $display("FAIL mid_no_done: got %0d pulses required 0", n_done);
    end
    min_lat = 1;
    max_lat = 20;
    run_inv({{(M-1){1'b0}}, 1'b1}, "mid_restart", zr, cyc);
    total++;
    if (zr !== {{(M-1){1'b0}}, 1'b1}) begin
      bad++;
      $display("FAIL mid_restart_z: got %h required 1", zr);
    end
  endtask

  task automatic test_zero();
    logic [M-1:0] zr;
    int cyc;
    min_lat = 1;
    max_lat = 10;
    run_inv('0, "zero", zr, cyc);
    total++;
    if (zr !== '0) begin
      bad++;
      $display("FAIL zero_z: got %h required 0", zr);
    end
`ifdef GF_INV_ZERO_FLAG_EN
    total++;
    if (inv_zero !== 1'b1) begin
      bad++;
      $display("FAIL zero_flag: got %b required 1", inv_zero);
    end
    total++;
    if (cyc > 3) begin
      bad++;
      $display("FAIL zero_latency: got %0d cycles required <= 3", cyc);
    end
`endif
    repeat (3) @(negedge clk);
    total++;
    if (n_done !== 1) begin
      bad++;
      $display("FAIL zero_done_count: got %0d required 1", n_done);
    end
  endtask

  initial begin
    test_reset();
    test_one();
    test_x();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
